hazard_ctrl: RTL

Pipeline hazard controller sitting between the decode stage and execute. It tracks destination registers of in-flight instructions in a small scoreboard shift pipe. It decides per cycle whether the instruction in ID may issue, must stall, or is killed by flush. It also produces operand forwarding selects for the EX input muxes, resolving RAW hazards that the decode stage only flags.

---
 rtl/hazard_ctrl_pkg.sv | 19 +
 rtl/hazard_ctrl_if.sv | 36 +++
 rtl/hazard_ctrl_src_check.sv | 38 +++
 rtl/hazard_ctrl.sv | 86 ++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline types for the hazard controller: forwarding selects,
// scoreboard slot layout and the register address width.
package hazard_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        FWD_REGFILE = 2'd0,
        FWD_SLOT0   = 2'd1,
        FWD_SLOT1   = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  is_load;
    } sb_slot_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage to hazard-controller bundle: decoded operand info in,
// issue/stall decision and EX forwarding selects out.
interface hazard_ctrl_if
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1_addr;
    logic                  id_rs1_en;
    logic [REG_ADDR_W-1:0] id_rs2_addr;
    logic                  id_rs2_en;
    logic [REG_ADDR_W-1:0] id_rd_addr;
    logic                  id_rd_en;
    logic                  id_rd_is_load;
    logic                  flush;
    logic                  stall;
    logic                  issue;
    fwd_sel_t              fwd_sel_a;
    fwd_sel_t              fwd_sel_b;
    logic [31:0]           busy_mask;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output id_valid, id_rs1_addr, id_rs1_en, id_rs2_addr, id_rs2_en,
               id_rd_addr, id_rd_en, id_rd_is_load, flush,
        input  stall, issue, fwd_sel_a, fwd_sel_b, busy_mask, stall_count
    );

    modport slave (
        input  id_valid, id_rs1_addr, id_rs1_en, id_rs2_addr, id_rs2_en,
               id_rd_addr, id_rd_en, id_rd_is_load, flush,
        output stall, issue, fwd_sel_a, fwd_sel_b, busy_mask, stall_count
    );

endinterface

// File: rtl/hazard_ctrl_src_check.sv
// Per-source RAW check against the scoreboard slots; the youngest matching
// slot alone decides between forwarding and stalling.
module hazard_src_check
    import hazard_ctrl_pkg::*;
#(
    parameter int WB_LATENCY = 2,
    parameter int FWD_EN     = 1
) (
    input  logic [REG_ADDR_W-1:0]       rs_addr_i,
    input  logic                        rs_en_i,
    input  sb_slot_t [WB_LATENCY-1:0]   slots_i,
    output logic                        stall_req_o,
    output fwd_sel_t                    fwd_sel_o
);

    // Walk oldest to youngest so a younger match overrides any older one.
    always_comb begin
        stall_req_o = 1'b0;
        fwd_sel_o   = FWD_REGFILE;
        for (int k = WB_LATENCY - 1; k >= 0; k--) begin
            if (rs_en_i && (rs_addr_i != '0) && slots_i[k].valid &&
                (slots_i[k].rd == rs_addr_i)) begin
                stall_req_o = 1'b1;
                fwd_sel_o   = FWD_REGFILE;
                if (FWD_EN != 0) begin
                    if ((k == 0) && !slots_i[k].is_load) begin
                        stall_req_o = 1'b0;
                        fwd_sel_o   = FWD_SLOT0;
                    end else if (k == 1) begin
                        stall_req_o = 1'b0;
                        fwd_sel_o   = FWD_SLOT1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode/execute hazard controller: scoreboard shift pipe of in-flight
// destinations, issue/stall/flush decision and operand forwarding selects.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int WB_LATENCY = 2,
    parameter int FWD_EN     = 1,
    parameter int CNT_W      = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    hazard_ctrl_if.slave hz
);

    sb_slot_t [WB_LATENCY-1:0] slot_q, slot_d;
    logic [CNT_W-1:0]          stall_cnt_q, stall_cnt_d;
    logic                      stall_a, stall_b;
    fwd_sel_t                  sel_a, sel_b;
    logic                      id_live, stall, issue;
    logic [31:0]               busy_mask;

    hazard_src_check #(.WB_LATENCY(WB_LATENCY), .FWD_EN(FWD_EN)) u_src_a (
        .rs_addr_i   (hz.id_rs1_addr),
        .rs_en_i     (hz.id_rs1_en),
        .slots_i     (slot_q),
        .stall_req_o (stall_a),
        .fwd_sel_o   (sel_a)
    );

    hazard_src_check #(.WB_LATENCY(WB_LATENCY), .FWD_EN(FWD_EN)) u_src_b (
        .rs_addr_i   (hz.id_rs2_addr),
        .rs_en_i     (hz.id_rs2_en),
        .slots_i     (slot_q),
        .stall_req_o (stall_b),
        .fwd_sel_o   (sel_b)
    );

    // Flush dominates: a killed instruction neither stalls nor issues.
    assign id_live = hz.id_valid && !hz.flush;
    assign stall   = id_live && (stall_a || stall_b);
    assign issue   = id_live && !stall;

    always_comb begin
        slot_d[0] = '{valid:   issue && hz.id_rd_en && (hz.id_rd_addr != '0),
                      rd:      hz.id_rd_addr,
                      is_load: hz.id_rd_is_load};
        for (int k = 1; k < WB_LATENCY; k++) begin
            slot_d[k] = slot_q[k-1];
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int k = 0; k < WB_LATENCY; k++) begin
            if (slot_q[k].valid) begin
                busy_mask[slot_q[k].rd] = 1'b1;
            end
        end
        busy_mask[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            slot_q      <= slot_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.stall       = stall;
    assign hz.issue       = issue;
    assign hz.fwd_sel_a   = issue ? sel_a : FWD_REGFILE;
    assign hz.fwd_sel_b   = issue ? sel_b : FWD_REGFILE;
    assign hz.busy_mask   = busy_mask;
    assign hz.stall_count = stall_cnt_q;

endmodule
